hazard_control_unit: RTL and testbench
======================================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: max consecutive memory-wait cycles before timeout error.
REQ-002 Parameter CNT_W, default 16: width of wait counter and stall statistics counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 IF_ID_Rs, IF_ID_Rt  in  5 each  source registers of the instruction in ID.
REQ-006 ID_UsesRt  in  1  ID instruction reads Rt as a source (R-type, store, beq/bne).
REQ-007 ID_EX_Rt  in  5  destination register of the instruction in EX.
REQ-008 ID_EX_MemRead  in  1  instruction in EX is a load.
REQ-009 Branch_Taken  in  1  branch/jump resolved taken in EX this cycle.
REQ-010 EX_MEM_MemAccess  in  1  instruction in MEM accesses data memory.
REQ-011 dmem_ready  in  1  data memory completes the access this cycle.
REQ-012 err_clear  in  1  synchronous clear of the sticky timeout error.
REQ-013 PC_Write  out  1  PC may update.
REQ-014 IF_ID_Write  out  1  IF/ID register may load.
REQ-015 IF_ID_Flush  out  1  IF/ID loads a NOP.
REQ-016 ID_EX_Bubble  out  1  ID/EX loads zeroed control signals.
REQ-017 Pipe_Freeze  out  1  ID/EX, EX/MEM, MEM/WB hold their contents.
REQ-018 mem_timeout  out  1  sticky memory-timeout error.
REQ-019 stall_cycles  out  CNT_W  count of cycles with PC_Write=0.

Function
REQ-020 FSM states SHALL be RUN, MEM_WAIT, TIMEOUT; encoding is free.
REQ-021 load_use SHALL be ID_EX_MemRead && ID_EX_Rt!=0 && (ID_EX_Rt==IF_ID_Rs || (ID_UsesRt && ID_EX_Rt==IF_ID_Rt)).
REQ-022 mem_stall SHALL be EX_MEM_MemAccess && !dmem_ready.
REQ-023 Control outputs SHALL be combinational from state and current inputs (zero-cycle latency); priority mem_stall > Branch_Taken > load_use.
REQ-024 In RUN with mem_stall: Pipe_Freeze=1, PC_Write=0, IF_ID_Write=0, IF_ID_Flush=0, ID_EX_Bubble=0; next state MEM_WAIT with wait counter loaded to 1.
REQ-025 In RUN with Branch_Taken and no mem_stall: IF_ID_Flush=1, ID_EX_Bubble=1, PC_Write=1, IF_ID_Write=1; load_use in the same cycle SHALL be ignored.
REQ-026 In RUN with load_use only: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; exactly one bubble per load, since the bubble clears ID_EX_MemRead.
REQ-027 In RUN with no hazard: PC_Write=1, IF_ID_Write=1, all other control outputs 0.
REQ-028 MEM_WAIT: freeze outputs as REQ-024 while mem_stall; wait counter increments each cycle.
REQ-029 MEM_WAIT: Branch_Taken and load_use SHALL be ignored while mem_stall holds.
REQ-030 MEM_WAIT: on dmem_ready the cycle behaves as RUN (REQ-025..027) and the next state is RUN.
REQ-031 MEM_WAIT: when the counter reaches MEM_TIMEOUT with mem_stall still 1, next state is TIMEOUT and mem_timeout is set.
REQ-032 TIMEOUT: Pipe_Freeze=1, PC_Write=0, IF_ID_Write=0, regardless of inputs.
REQ-033 TIMEOUT: err_clear=1 clears mem_timeout and the next state is RUN.
REQ-034 err_clear in RUN or MEM_WAIT SHALL have no effect.

Reset
REQ-035 rst_n=0 SHALL immediately force state RUN, wait counter 0, mem_timeout 0, stall_cycles 0.
REQ-036 While rst_n=0: PC_Write=0, IF_ID_Write=0, IF_ID_Flush=0, ID_EX_Bubble=0, Pipe_Freeze=0.
REQ-037 Reset asserted mid-MEM_WAIT or in TIMEOUT SHALL abort the wait with no residual freeze after release.

Configuration
REQ-038 With HAZARD_STATS_EN defined, stall_cycles SHALL increment on every cycle with PC_Write=0 outside reset, saturating at all-ones.
REQ-039 Without HAZARD_STATS_EN, the stall_cycles port SHALL remain present and be driven constant 0.

Verification
REQ-040 ID_EX_MemRead=1, ID_EX_Rt=8, IF_ID_Rs=8 for one cycle -> PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1 that cycle only.
REQ-041 Same as REQ-040 plus Branch_Taken=1 -> IF_ID_Flush=1, ID_EX_Bubble=1, PC_Write=1; ID_EX_Rt=0 with the load -> no stall.
REQ-042 EX_MEM_MemAccess=1, dmem_ready=0 for 3 cycles, then 1 -> Pipe_Freeze=1 for 3 cycles, RUN on the 4th; stall_cycles=3 with HAZARD_STATS_EN.
REQ-043 dmem_ready held 0 for 20 cycles, MEM_TIMEOUT=15 -> mem_timeout=1 after cycle 15, freeze held; err_clear pulse -> RUN, mem_timeout=0.
REQ-044 rst_n driven low asynchronously mid-MEM_WAIT -> all outputs to REQ-036 values immediately; RUN after release.
REQ-045 HAZARD_STATS_EN with CNT_W=4, 20 stall cycles -> stall_cycles saturates at 15; without macro -> stall_cycles=0 throughout.

Source files
------------

// File: rtl/hazard_control_unit.sv
// hazard_control_unit
// Pipeline hazard controller for a five-stage in-order core. Resolves
// load-use stalls, taken-branch flushes and data-memory wait states, and
// raises a sticky error when a memory access waits too long.
// Outputs are combinational from the FSM state and the current inputs so the
// pipeline sees the decision in the same cycle.
// Optional build macro: HAZARD_STATS_EN enables the stall_cycles statistics
// counter; without it the port stays present and reads constant 0.
module hazard_control_unit #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_Rs,
    input  logic [4:0]       IF_ID_Rt,
    input  logic             ID_UsesRt,
    input  logic [4:0]       ID_EX_Rt,
    input  logic             ID_EX_MemRead,
    input  logic             Branch_Taken,
    input  logic             EX_MEM_MemAccess,
    input  logic             dmem_ready,
    input  logic             err_clear,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             Pipe_Freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE_CNT     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    state_t           state_reg;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic [CNT_W-1:0] wait_cnt_next;
    logic             mem_timeout_reg;

    logic load_use;
    logic mem_stall;

    // Hazard detection from the current pipeline contents
    always_comb begin
        load_use  = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                    ((ID_EX_Rt == IF_ID_Rs) || (ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));
        mem_stall = EX_MEM_MemAccess && !dmem_ready;
    end

    // Control outputs: reset gating first, then freeze > flush > load-use bubble
    always_comb begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        Pipe_Freeze  = 1'b0;
        if (rst_n) begin
            if (state_reg == TIMEOUT || mem_stall) begin
                // Whole pipeline holds; front end neither advances nor flushes
                Pipe_Freeze = 1'b1;
            end else if (Branch_Taken) begin
                // Wrong-path instructions in IF/ID and ID are squashed; any
                // load-use hazard belongs to a squashed instruction
                PC_Write     = 1'b1;
                IF_ID_Write  = 1'b1;
                IF_ID_Flush  = 1'b1;
                ID_EX_Bubble = 1'b1;
            end else if (load_use) begin
                // Hold IF and ID, inject one bubble; the bubble clears
                // ID_EX_MemRead so the stall lasts exactly one cycle
                ID_EX_Bubble = 1'b1;
            end else begin
                PC_Write    = 1'b1;
                IF_ID_Write = 1'b1;
            end
        end
    end

    // Wait counter value after one more stalled cycle
    always_comb begin
        wait_cnt_next = (state_reg == MEM_WAIT) ? (wait_cnt_reg + ONE_CNT) : ONE_CNT;
    end

    // FSM: tracks memory wait duration and the sticky timeout error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= RUN;
            wait_cnt_reg    <= '0;
            mem_timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                RUN, MEM_WAIT: begin
                    if (mem_stall) begin
                        wait_cnt_reg <= wait_cnt_next;
                        if (wait_cnt_next >= TIMEOUT_CNT) begin
                            state_reg       <= TIMEOUT;
                            mem_timeout_reg <= 1'b1;
                        end else begin
                            state_reg <= MEM_WAIT;
                        end
                    end else begin
                        // Access completed (or none pending): back to normal flow
                        state_reg    <= RUN;
                        wait_cnt_reg <= '0;
                    end
                end
                TIMEOUT: begin
                    if (err_clear) begin
                        state_reg       <= RUN;
                        wait_cnt_reg    <= '0;
                        mem_timeout_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= RUN;
                    wait_cnt_reg <= '0;
                end
            endcase
        end
    end

    assign mem_timeout = mem_timeout_reg;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_reg;

    // Saturating count of cycles in which the PC did not advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (!PC_Write && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + ONE_CNT;
        end
    end

    assign stall_cycles = stall_cnt_reg;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Testbench for hazard_control_unit: directed scenarios plus randomized
// traffic, checked against a behavioural model of the hazard rules.
// A second instance with a 4-bit counter exercises statistics saturation.
module tb_hazard_control_unit;

    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 16;
    localparam int SAT_W       = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] IF_ID_Rs, IF_ID_Rt, ID_EX_Rt;
    logic       ID_UsesRt, ID_EX_MemRead, Branch_Taken;
    logic       EX_MEM_MemAccess, dmem_ready, err_clear;

    logic             PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze, mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic             s_pc, s_ifw, s_fl, s_bub, s_pf, s_to;
    logic [SAT_W-1:0] s_stall;

    int checks   = 0;
    int failures = 0;

    // Model state: 0 = running, 1 = waiting on memory, 2 = timed out
    int m_mode, m_wait, m_stalls, m_stalls4;
    bit m_err;

    always #5 clk = ~clk;

    hazard_control_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .ID_UsesRt(ID_UsesRt),
        .ID_EX_Rt(ID_EX_Rt), .ID_EX_MemRead(ID_EX_MemRead),
        .Branch_Taken(Branch_Taken), .EX_MEM_MemAccess(EX_MEM_MemAccess),
        .dmem_ready(dmem_ready), .err_clear(err_clear),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Bubble(ID_EX_Bubble), .Pipe_Freeze(Pipe_Freeze),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    hazard_control_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(SAT_W)) u_dut_sat (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .ID_UsesRt(ID_UsesRt),
        .ID_EX_Rt(ID_EX_Rt), .ID_EX_MemRead(ID_EX_MemRead),
        .Branch_Taken(Branch_Taken), .EX_MEM_MemAccess(EX_MEM_MemAccess),
        .dmem_ready(dmem_ready), .err_clear(err_clear),
        .PC_Write(s_pc), .IF_ID_Write(s_ifw), .IF_ID_Flush(s_fl),
        .ID_EX_Bubble(s_bub), .Pipe_Freeze(s_pf),
        .mem_timeout(s_to), .stall_cycles(s_stall)
    );

    wire [5:0] outs     = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze, mem_timeout};
    wire [5:0] sat_outs = {s_pc, s_ifw, s_fl, s_bub, s_pf, s_to};

    // ---------------- behavioural reference model ----------------
    task automatic model_reset();
        m_mode = 0; m_wait = 0; m_err = 0; m_stalls = 0; m_stalls4 = 0;
    endtask

    // Expected {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze, mem_timeout}
    function automatic logic [5:0] exp_outs();
        logic ms, lu;
        if (!rst_n) return 6'b000000;
        ms = EX_MEM_MemAccess && !dmem_ready;
        lu = ID_EX_MemRead && (ID_EX_Rt != 0) &&
             ((ID_EX_Rt == IF_ID_Rs) || (ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));
        if (m_mode == 2 || ms) return {5'b00001, m_err};
        if (Branch_Taken)      return {5'b11110, m_err};
        if (lu)                return {5'b00010, m_err};
        return {5'b11000, m_err};
    endfunction

    function automatic logic [CNT_W-1:0] exp_stall();
`ifdef HAZARD_STATS_EN
        return CNT_W'(m_stalls);
`else
        return '0;
`endif
    endfunction

    function automatic logic [SAT_W-1:0] exp_stall4();
`ifdef HAZARD_STATS_EN
        return SAT_W'(m_stalls4);
`else
        return '0;
`endif
    endfunction

    // Applies one rising edge to the model using the inputs present before it
    task automatic model_advance();
        logic [5:0] e;
        logic ms;
        if (!rst_n) begin
            model_reset();
            return;
        end
        e  = exp_outs();
        ms = EX_MEM_MemAccess && !dmem_ready;
        if (!e[5]) begin
            if (m_stalls < (1 << CNT_W) - 1) m_stalls++;
            if (m_stalls4 < (1 << SAT_W) - 1) m_stalls4++;
        end
        if (m_mode == 2) begin
            if (err_clear) begin
                m_mode = 0; m_wait = 0; m_err = 0;
            end
        end else if (ms) begin
            m_wait = (m_mode == 0) ? 1 : m_wait + 1;
            if (m_wait >= MEM_TIMEOUT) begin
                m_mode = 2; m_err = 1;
            end else begin
                m_mode = 1;
            end
        end else begin
            m_mode = 0; m_wait = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic idle_inputs();
        IF_ID_Rs = 5'd1; IF_ID_Rt = 5'd2; ID_UsesRt = 1'b0; ID_EX_Rt = 5'd3;
        ID_EX_MemRead = 1'b0; Branch_Taken = 1'b0; EX_MEM_MemAccess = 1'b0;
        dmem_ready = 1'b1; err_clear = 1'b0;
    endtask

    task automatic random_inputs(input int ready_pct);
        IF_ID_Rs         = 5'($urandom_range(0, 3));
        IF_ID_Rt         = 5'($urandom_range(0, 3));
        ID_EX_Rt         = 5'($urandom_range(0, 3));
        ID_UsesRt        = 1'($urandom_range(0, 1));
        ID_EX_MemRead    = ($urandom_range(0, 99) < 40);
        Branch_Taken     = ($urandom_range(0, 99) < 20);
        EX_MEM_MemAccess = ($urandom_range(0, 99) < 40);
        dmem_ready       = ($urandom_range(0, 99) < ready_pct);
        err_clear        = ($urandom_range(0, 99) < 15);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            random_inputs(50);
            #1;
            checks++;
            if (outs !== 6'b0 || sat_outs !== 6'b0 || stall_cycles !== '0) begin
                failures++;
                $display("FAIL reset cyc=%0d outs=%b sat=%b stall=%0d expected all 0", i, outs, sat_outs, stall_cycles);
            end else $display("reset cyc=%0d outs=%b", i, outs);
            tick();
        end
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        logic [5:0] e;
        // cycle 0: load r8 in EX, ID reads r8 -> one bubble
        // cycle 1: bubble cleared MemRead -> normal flow
        // cycle 2: load-use plus taken branch -> flush wins
        // cycle 3: load into r0 -> no hazard
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            case (i)
                0: begin ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd8; IF_ID_Rs = 5'd8; end
                1: begin ID_EX_Rt = 5'd8; IF_ID_Rs = 5'd8; end
                2: begin ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd8; IF_ID_Rs = 5'd8; Branch_Taken = 1'b1; end
                default: begin ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd0; IF_ID_Rs = 5'd0; end
            endcase
            #1;
            e = exp_outs();
            checks++;
            if (outs !== e || sat_outs !== e) begin
                failures++;
                $display("FAIL load_use step=%0d outs=%b sat=%b expected %b", i, outs, sat_outs, e);
            end else $display("load_use step=%0d outs=%b", i, outs);
            tick();
        end
        checks++;
        if (stall_cycles !== exp_stall()) begin
            failures++;
            $display("FAIL load_use_stats stall=%0d expected %0d", stall_cycles, exp_stall());
        end
    endtask

    task automatic test_mem_wait();
        logic [5:0] e;
        logic [CNT_W-1:0] base;
        base = exp_stall();
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            EX_MEM_MemAccess = (i < 4);
            dmem_ready       = (i >= 3);
            Branch_Taken     = (i == 1);   // must be ignored while frozen
            #1;
            e = exp_outs();
            checks++;
            if (outs !== e || sat_outs !== e) begin
                failures++;
                $display("FAIL mem_wait step=%0d outs=%b sat=%b expected %b", i, outs, sat_outs, e);
            end else $display("mem_wait step=%0d outs=%b", i, outs);
            tick();
        end
        checks++;
`ifdef HAZARD_STATS_EN
        if (stall_cycles - base !== CNT_W'(3)) begin
`else
        if (stall_cycles !== '0 || base !== '0) begin
`endif
            failures++;
            $display("FAIL mem_wait_stats stall=%0d base=%0d", stall_cycles, base);
        end
    endtask

    task automatic test_timeout();
        logic [5:0] e;
        for (int i = 0; i < 23; i++) begin
            random_inputs(0);
            EX_MEM_MemAccess = (i < 20);
            err_clear        = (i == 21);
            #1;
            e = exp_outs();
            checks++;
            if (outs !== e || sat_outs !== e) begin
                failures++;
                $display("FAIL timeout step=%0d outs=%b sat=%b expected %b", i, outs, sat_outs, e);
            end else $display("timeout step=%0d outs=%b", i, outs);
            checks++;
            if (stall_cycles !== exp_stall() || s_stall !== exp_stall4()) begin
                failures++;
                $display("FAIL timeout_stats step=%0d stall=%0d sat=%0d expected %0d/%0d",
                         i, stall_cycles, s_stall, exp_stall(), exp_stall4());
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        logic [5:0] e;
        idle_inputs();
        EX_MEM_MemAccess = 1'b1; dmem_ready = 1'b0;
        tick();
        tick();   // now waiting on memory
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (outs !== 6'b0 || sat_outs !== 6'b0 || stall_cycles !== '0 || s_stall !== '0) begin
            failures++;
            $display("FAIL async_reset outs=%b sat=%b stall=%0d expected all 0", outs, sat_outs, stall_cycles);
        end else $display("async_reset outs=%b", outs);
        tick();
        rst_n = 1'b1;
        idle_inputs();
        #1;
        e = exp_outs();
        checks++;
        if (outs !== e || outs !== 6'b110000) begin
            failures++;
            $display("FAIL after_reset outs=%b expected %b", outs, 6'b110000);
        end else $display("after_reset outs=%b", outs);
        tick();
    endtask

    task automatic test_random();
        logic [5:0] e;
        int ready_pct;
        for (int i = 0; i < 2000; i++) begin
            ready_pct = ((i / 100) % 3 == 0) ? 3 : 60;
            random_inputs(ready_pct);
            #1;
            e = exp_outs();
            checks++;
            if (outs !== e || sat_outs !== e) begin
                failures++;
                $display("FAIL random cyc=%0d outs=%b sat=%b expected %b", i, outs, sat_outs, e);
            end
            checks++;
            if (stall_cycles !== exp_stall() || s_stall !== exp_stall4()) begin
                failures++;
                $display("FAIL random_stats cyc=%0d stall=%0d sat=%0d expected %0d/%0d",
                         i, stall_cycles, s_stall, exp_stall(), exp_stall4());
            end
            tick();
        end
        $display("random done cycles=2000 stall=%0d", stall_cycles);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
